// File: rtl/k423_wb_stage.sv
// k423_wb_stage: write-back pipeline register, load alignment, register-file write, retire and instret count
module k423_wb_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ex_stage_vld_i,
  output logic        wb_stage_rdy_o,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_rd_vld_i,
  input  logic [4:0]  ex_rd_idx_i,
  input  logic [31:0] ex_rd_i,
  input  logic        ex_rd_load_i,
  input  logic        ex_rd_load_unsigned_i,
  input  logic [1:0]  ex_rd_load_size_i,
  input  logic [1:0]  ex_mem_addr_i,
  input  logic        mem_rsp_vld_i,
  input  logic [31:0] mem_rsp_rdata_i,
  output logic        wb_rf_wen_o,
  output logic [4:0]  wb_rf_widx_o,
  output logic [31:0] wb_rf_wdata_o,
  output logic        wb_load_pend_o,
  output logic [31:0] wb_pc_o,
  output logic        wb_retire_o,
  output logic [63:0] wb_instret_o
);
  logic        v, rd_vld, load, uns;
  logic [31:0] pc, rd;
  logic [4:0]  rd_idx;
  logic [1:0]  size, off;
  logic        commit, cap;
  logic [31:0] sh, ld;
  assign commit         = v & (~load | mem_rsp_vld_i);
  assign wb_stage_rdy_o = ~v | commit;
  assign cap            = ex_stage_vld_i & wb_stage_rdy_o;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      v            <= 1'b0;
      pc           <= '0;
      rd_vld       <= 1'b0;
      rd_idx       <= '0;
      rd           <= '0;
      load         <= 1'b0;
      uns          <= 1'b0;
      size         <= '0;
      off          <= '0;
      wb_instret_o <= '0;
    end else begin
      if (cap) begin
        v      <= 1'b1;
        pc     <= ex_pc_i;
        rd_vld <= ex_rd_vld_i;
        rd_idx <= ex_rd_idx_i;
        rd     <= ex_rd_i;
        load   <= ex_rd_load_i;
        uns    <= ex_rd_load_unsigned_i;
        size   <= ex_rd_load_size_i;
        off    <= ex_mem_addr_i;
      end else if (commit) begin
        v <= 1'b0;
      end
      if (commit) wb_instret_o <= wb_instret_o + 64'd1;
    end
  // word and reserved sizes take the response as-is, ignoring the offset
  always_comb begin
    sh = mem_rsp_rdata_i >> {off, 3'b000};
    ld = size == 2'd0 ? {{24{~uns & sh[7]}}, sh[7:0]} :
         size == 2'd1 ? {{16{~uns & sh[15]}}, sh[15:0]} : mem_rsp_rdata_i;
  end
  assign wb_rf_wen_o    = commit & rd_vld & (rd_idx != 5'd0);
  assign wb_rf_widx_o   = rd_idx;
  assign wb_rf_wdata_o  = load ? ld : rd;
  assign wb_load_pend_o = v & load & ~mem_rsp_vld_i;
  assign wb_pc_o        = pc;
  assign wb_retire_o    = commit;
endmodule

// File: tb/tb_k423_wb_stage.sv
// tb_k423_wb_stage: directed and randomized checks of k423_wb_stage against a behavioural model
module tb_k423_wb_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic        rdv;
    logic [4:0]  idx;
    logic [31:0] rd;
    logic        ld;
    logic        uns;
    logic [1:0]  sz;
    logic [1:0]  off;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ex_stage_vld_i = 1'b0;
  logic        wb_stage_rdy_o;
  logic [31:0] ex_pc_i = '0;
  logic        ex_rd_vld_i = 1'b0;
  logic [4:0]  ex_rd_idx_i = '0;
  logic [31:0] ex_rd_i = '0;
  logic        ex_rd_load_i = 1'b0;
  logic        ex_rd_load_unsigned_i = 1'b0;
  logic [1:0]  ex_rd_load_size_i = '0;
  logic [1:0]  ex_mem_addr_i = '0;
  logic        mem_rsp_vld_i = 1'b0;
  logic [31:0] mem_rsp_rdata_i = '0;
  logic        wb_rf_wen_o;
  logic [4:0]  wb_rf_widx_o;
  logic [31:0] wb_rf_wdata_o;
  logic        wb_load_pend_o;
  logic [31:0] wb_pc_o;
  logic        wb_retire_o;
  logic [63:0] wb_instret_o;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_cnt = '0;

  always #5 clk = ~clk;

  k423_wb_stage dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .ex_stage_vld_i(ex_stage_vld_i), .wb_stage_rdy_o(wb_stage_rdy_o),
    .ex_pc_i(ex_pc_i), .ex_rd_vld_i(ex_rd_vld_i), .ex_rd_idx_i(ex_rd_idx_i), .ex_rd_i(ex_rd_i),
    .ex_rd_load_i(ex_rd_load_i), .ex_rd_load_unsigned_i(ex_rd_load_unsigned_i),
    .ex_rd_load_size_i(ex_rd_load_size_i), .ex_mem_addr_i(ex_mem_addr_i),
    .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
    .wb_rf_wen_o(wb_rf_wen_o), .wb_rf_widx_o(wb_rf_widx_o), .wb_rf_wdata_o(wb_rf_wdata_o),
    .wb_load_pend_o(wb_load_pend_o), .wb_pc_o(wb_pc_o), .wb_retire_o(wb_retire_o),
    .wb_instret_o(wb_instret_o)
  );

  function automatic ins_t mk(input logic [31:0] pc, input logic rdv, input logic [4:0] idx,
                              input logic [31:0] rd, input logic ld, input logic uns,
                              input logic [1:0] sz, input logic [1:0] off);
    ins_t i;
    i.pc = pc; i.rdv = rdv; i.idx = idx; i.rd = rd; i.ld = ld; i.uns = uns; i.sz = sz; i.off = off;
    return i;
  endfunction

  // extract the addressed byte/half numerically, then apply two's-complement sign wrap
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
    longint unsigned x;
    logic [31:0] r;
    x = 64'(rdata) >> (8 * int'(off));
    if (sz == 2'd0) begin
      r = 32'(x % 256);
      if (!uns && r >= 32'd128) r = r - 32'd256;
    end else if (sz == 2'd1) begin
      r = 32'(x % 65536);
      if (!uns && r >= 32'd32768) r = r - 32'd65536;
    end else r = rdata;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic vld, input ins_t i);
    ex_stage_vld_i = vld;
    ex_pc_i = i.pc; ex_rd_vld_i = i.rdv; ex_rd_idx_i = i.idx; ex_rd_i = i.rd;
    ex_rd_load_i = i.ld; ex_rd_load_unsigned_i = i.uns; ex_rd_load_size_i = i.sz; ex_mem_addr_i = i.off;
  endtask

  task automatic test_reset();
    #12;
    @(negedge clk);
    checks++;
    if (wb_stage_rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy act=%b exp=1", wb_stage_rdy_o); end
    checks++;
    if ({wb_rf_wen_o, wb_load_pend_o, wb_retire_o} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl act=%b exp=000", {wb_rf_wen_o, wb_load_pend_o, wb_retire_o});
    end
    checks++;
    if (wb_instret_o !== 64'd0 || wb_pc_o !== 32'd0 || wb_rf_wdata_o !== 32'd0 || wb_rf_widx_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_data act=instret %0h pc %h wdata %h widx %0d exp=all 0", wb_instret_o, wb_pc_o, wb_rf_wdata_o, wb_rf_widx_o);
    end
    cyc();
    rst_n_i = 1'b1;
  endtask

  task automatic test_alu();
    cyc();
    set_ex(1'b1, mk(32'h100, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 2'd0));
    cyc();
    ex_stage_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_rf_wen_o !== 1'b1 || wb_rf_widx_o !== 5'd5 || wb_rf_wdata_o !== 32'h1234_5678 || wb_retire_o !== 1'b1) begin
      failures++;
      $display("FAIL alu_write act=wen %b idx %0d data %h ret %b exp=1 5 12345678 1", wb_rf_wen_o, wb_rf_widx_o, wb_rf_wdata_o, wb_retire_o);
    end
    checks++;
    if (wb_pc_o !== 32'h100) begin failures++; $display("FAIL alu_pc act=%h exp=00000100", wb_pc_o); end
    cyc();
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (wb_instret_o !== exp_cnt || wb_retire_o !== 1'b0) begin
      failures++; $display("FAIL alu_count act=%0d ret %b exp=%0d ret 0", wb_instret_o, wb_retire_o, exp_cnt);
    end
  endtask

  task automatic test_load_align();
    logic [1:0]  sz_t [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    logic [1:0]  off_t[6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2};
    logic        uns_t[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] rd_t [6] = '{32'h80AA_BBCC, 32'h80AA_BBCC, 32'h8001_0000, 32'h8001_0000, 32'h80AA_BBCC, 32'hDEAD_BEEF};
    logic [31:0] exp_t[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_0080, 32'hDEAD_BEEF};
    for (int n = 0; n < 30; n++) begin
      logic [1:0]  sz, off;
      logic        uns;
      logic [31:0] rdata, exp;
      if (n < 6) begin
        sz = sz_t[n]; off = off_t[n]; uns = uns_t[n]; rdata = rd_t[n]; exp = exp_t[n];
      end else begin
        sz = 2'($urandom); off = 2'($urandom); uns = 1'($urandom); rdata = $urandom;
        exp = ref_load(rdata, sz, off, uns);
      end
      cyc();
      set_ex(1'b1, mk($urandom, 1'b1, 5'(n % 31 + 1), $urandom, 1'b1, uns, sz, off));
      cyc();
      ex_stage_vld_i = 1'b0;
      mem_rsp_vld_i = 1'b1;
      mem_rsp_rdata_i = rdata;
      @(negedge clk);
      checks++;
      if (wb_rf_wdata_o !== exp || wb_rf_wen_o !== 1'b1) begin
        failures++;
        $display("FAIL load_align[%0d] sz %0d off %0d uns %b rdata %h act=%h wen %b exp=%h wen 1", n, sz, off, uns, rdata, wb_rf_wdata_o, wb_rf_wen_o, exp);
      end
      cyc();
      mem_rsp_vld_i = 1'b0;
      exp_cnt++;
    end
  endtask

  task automatic test_load_wait();
    logic [31:0] rdata = $urandom;
    cyc();
    set_ex(1'b1, mk(32'h200, 1'b1, 5'd9, 32'h0, 1'b1, 1'b0, 2'd2, 2'd1));
    cyc();
    set_ex(1'b1, mk(32'h204, 1'b1, 5'd10, 32'hCAFE_0010, 1'b0, 1'b0, 2'd0, 2'd0));
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checks++;
      if (wb_stage_rdy_o !== 1'b0 || wb_load_pend_o !== 1'b1 || wb_rf_wen_o !== 1'b0 || wb_retire_o !== 1'b0) begin
        failures++;
        $display("FAIL load_wait[%0d] act=rdy %b pend %b wen %b ret %b exp=0 1 0 0", w, wb_stage_rdy_o, wb_load_pend_o, wb_rf_wen_o, wb_retire_o);
      end
      cyc();
    end
    mem_rsp_vld_i = 1'b1;
    mem_rsp_rdata_i = rdata;
    @(negedge clk);
    checks++;
    if (wb_rf_wen_o !== 1'b1 || wb_rf_widx_o !== 5'd9 || wb_rf_wdata_o !== rdata || wb_stage_rdy_o !== 1'b1 || wb_load_pend_o !== 1'b0) begin
      failures++;
      $display("FAIL load_rsp act=wen %b idx %0d data %h rdy %b pend %b exp=1 9 %h 1 0", wb_rf_wen_o, wb_rf_widx_o, wb_rf_wdata_o, wb_stage_rdy_o, wb_load_pend_o, rdata);
    end
    cyc();
    ex_stage_vld_i = 1'b0;
    mem_rsp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_rf_wen_o !== 1'b1 || wb_rf_widx_o !== 5'd10 || wb_rf_wdata_o !== 32'hCAFE_0010 || wb_pc_o !== 32'h204) begin
      failures++;
      $display("FAIL load_next act=wen %b idx %0d data %h pc %h exp=1 10 cafe0010 00000204", wb_rf_wen_o, wb_rf_widx_o, wb_rf_wdata_o, wb_pc_o);
    end
    cyc();
    exp_cnt += 2;
    @(negedge clk);
    checks++;
    if (wb_instret_o !== exp_cnt) begin failures++; $display("FAIL load_count act=%0d exp=%0d", wb_instret_o, exp_cnt); end
  endtask

  task automatic test_x0_nord();
    cyc();
    set_ex(1'b1, mk(32'h300, 1'b1, 5'd0, 32'h1111_1111, 1'b0, 1'b0, 2'd0, 2'd0));
    cyc();
    set_ex(1'b1, mk(32'h304, 1'b0, 5'd7, 32'h2222_2222, 1'b0, 1'b0, 2'd0, 2'd0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (wb_rf_wen_o !== 1'b0 || wb_retire_o !== 1'b1) begin
        failures++; $display("FAIL x0_nord[%0d] act=wen %b ret %b exp=0 1", k, wb_rf_wen_o, wb_retire_o);
      end
      cyc();
      ex_stage_vld_i = 1'b0;
    end
    exp_cnt += 2;
    @(negedge clk);
    checks++;
    if (wb_instret_o !== exp_cnt) begin failures++; $display("FAIL x0_count act=%0d exp=%0d", wb_instret_o, exp_cnt); end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] vals[4];
    cyc();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        vals[k] = $urandom;
        set_ex(1'b1, mk(32'h400 + 32'(4 * k), 1'b1, 5'(k + 1), vals[k], 1'b0, 1'b0, 2'd0, 2'd0));
      end else ex_stage_vld_i = 1'b0;
      if (k > 0) begin
        @(negedge clk);
        checks++;
        if (wb_rf_wen_o !== 1'b1 || wb_rf_widx_o !== 5'(k) || wb_rf_wdata_o !== vals[k - 1] || wb_stage_rdy_o !== 1'b1) begin
          failures++;
          $display("FAIL b2b[%0d] act=wen %b idx %0d data %h rdy %b exp=1 %0d %h 1", k, wb_rf_wen_o, wb_rf_widx_o, wb_rf_wdata_o, wb_stage_rdy_o, k, vals[k - 1]);
        end
      end
      cyc();
    end
    exp_cnt += 4;
    set_ex(1'b1, mk(32'h500, 1'b1, 5'd12, 32'h0, 1'b1, 1'b0, 2'd2, 2'd0));
    cyc();
    ex_stage_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_load_pend_o !== 1'b1 || wb_instret_o !== exp_cnt) begin
      failures++; $display("FAIL pre_reset act=pend %b cnt %0d exp=1 %0d", wb_load_pend_o, wb_instret_o, exp_cnt);
    end
    cyc();
    rst_n_i = 1'b0;
    exp_cnt = '0;
    #1;
    checks++;
    if (wb_stage_rdy_o !== 1'b1 || wb_load_pend_o !== 1'b0 || wb_rf_wen_o !== 1'b0 || wb_instret_o !== 64'd0 || wb_pc_o !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset act=rdy %b pend %b wen %b cnt %0d pc %h exp=1 0 0 0 0", wb_stage_rdy_o, wb_load_pend_o, wb_rf_wen_o, wb_instret_o, wb_pc_o);
    end
    cyc();
    rst_n_i = 1'b1;
    mem_rsp_vld_i = 1'b1;
    mem_rsp_rdata_i = $urandom;
    @(negedge clk);
    checks++;
    if (wb_rf_wen_o !== 1'b0 || wb_retire_o !== 1'b0) begin
      failures++; $display("FAIL late_rsp act=wen %b ret %b exp=0 0", wb_rf_wen_o, wb_retire_o);
    end
    cyc();
    mem_rsp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_instret_o !== 64'd0) begin failures++; $display("FAIL late_count act=%0d exp=0", wb_instret_o); end
  endtask

  // model: one optional held instruction; handshake and commit follow the stage's protocol rules
  task automatic test_random();
    logic m_v = 1'b0;
    ins_t m_i = '0;
    for (int n = 0; n < 500; n++) begin
      ins_t ri;
      logic evld, e_commit, e_rdy, e_wen, e_pend;
      cyc();
      ri = mk($urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
      evld = $urandom_range(0, 3) != 0;
      set_ex(evld, ri);
      mem_rsp_vld_i = 1'($urandom);
      mem_rsp_rdata_i = $urandom;
      @(negedge clk);
      e_commit = m_v && (!m_i.ld || mem_rsp_vld_i);
      e_rdy = !m_v || e_commit;
      e_wen = e_commit && m_i.rdv && m_i.idx != 5'd0;
      e_pend = m_v && m_i.ld && !mem_rsp_vld_i;
      checks++;
      if ({wb_stage_rdy_o, wb_rf_wen_o, wb_retire_o, wb_load_pend_o} !== {e_rdy, e_wen, e_commit, e_pend}) begin
        failures++;
        $display("FAIL rnd_ctl[%0d] act=rdy/wen/ret/pend %b exp=%b", n, {wb_stage_rdy_o, wb_rf_wen_o, wb_retire_o, wb_load_pend_o}, {e_rdy, e_wen, e_commit, e_pend});
      end
      checks++;
      if (wb_instret_o !== exp_cnt) begin failures++; $display("FAIL rnd_count[%0d] act=%0d exp=%0d", n, wb_instret_o, exp_cnt); end
      if (m_v) begin
        logic [31:0] e_wd;
        e_wd = m_i.ld ? ref_load(mem_rsp_rdata_i, m_i.sz, m_i.off, m_i.uns) : m_i.rd;
        checks++;
        if (wb_rf_widx_o !== m_i.idx || wb_pc_o !== m_i.pc || (e_commit && wb_rf_wdata_o !== e_wd)) begin
          failures++;
          $display("FAIL rnd_data[%0d] act=idx %0d pc %h data %h exp=%0d %h %h", n, wb_rf_widx_o, wb_pc_o, wb_rf_wdata_o, m_i.idx, m_i.pc, e_wd);
        end
      end
      if (evld && e_rdy) begin m_v = 1'b1; m_i = ri; end
      else if (e_commit) m_v = 1'b0;
      if (e_commit) exp_cnt++;
    end
    cyc();
    ex_stage_vld_i = 1'b0;
    mem_rsp_vld_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_align();
    test_load_wait();
    test_x0_nord();
    test_back_to_back_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
